// File: rtl/ufm_pkg.sv
// rtl/ufm_pkg.sv - shared op encodings, FSM states and defaults for the UFM sequencer
package ufm_pkg;

  localparam int AW_DEF            = 9;
  localparam int DW_DEF            = 16;
  localparam int BUSY_RISE_MAX_DEF = 16;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ASHIFT,
    DLOAD,
    DSHIFT,
    PULSE,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

endpackage

// File: rtl/ufm_busy_sync.sv
// rtl/ufm_busy_sync.sv - two-flop synchroniser for the combined UFM/RTP busy flags
module ufm_busy_sync (
  input  logic clk,
  input  logic rst,
  input  logic ufm_busy,
  input  logic rtp_busy,
  output logic busy
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      busy <= 1'b0;
    end else begin
      meta <= ufm_busy | rtp_busy;
      busy <= meta;
    end
  end

endmodule

// File: rtl/ufm_sequencer.sv
// rtl/ufm_sequencer.sv - arbitrates two requesters and drives the serial UFM access sequence
module ufm_sequencer
  import ufm_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int BUSY_RISE_MAX = BUSY_RISE_MAX_DEF,
  parameter int TIMEOUT_W     = 20
) (
  input  logic          C14M,
  input  logic          Rst,
  input  logic          Req0Valid,
  input  logic [1:0]    Req0Op,
  input  logic [AW-1:0] Req0Addr,
  input  logic [DW-1:0] Req0WData,
  output logic          Req0Ready,
  input  logic          Req1Valid,
  input  logic [1:0]    Req1Op,
  input  logic [AW-1:0] Req1Addr,
  input  logic [DW-1:0] Req1WData,
  output logic          Req1Ready,
  output logic          RspValid,
  output logic          RspId,
  output logic [DW-1:0] RspRData,
  output logic          RspErr,
  output logic          ARCLK,
  output logic          ARDIn,
  output logic          ARShift,
  output logic          DRCLK,
  output logic          DRDIn,
  output logic          DRShift,
  output logic          UFMErase,
  output logic          UFMProgram,
  input  logic          UFMBusy,
  input  logic          RTPBusy,
  input  logic          DRDOut
);

  localparam int CW = $clog2(2*AW + 2*DW + BUSY_RISE_MAX + 1);
  localparam logic [CW-1:0] ASHIFT_LAST = CW'(2*AW - 1);
  localparam logic [CW-1:0] DSHIFT_LAST = CW'(2*DW - 1);
  localparam logic [CW-1:0] RISE_LAST   = CW'(BUSY_RISE_MAX - 1);
  // Leaves WAIT_LO after 2^TIMEOUT_W-1 busy cycles.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state, state_d;
  logic [1:0]           op_q;
  logic [AW-1:0]        ash_q;
  logic [DW-1:0]        wsh_q, rsh_q;
  logic                 id_q, err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
  logic                 busy, accept, accept_id;
  logic [1:0]           sel_op;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;

  ufm_busy_sync u_busy_sync (
    .clk      (C14M),
    .rst      (Rst),
    .ufm_busy (UFMBusy),
    .rtp_busy (RTPBusy),
    .busy     (busy)
  );

  assign sel_op    = Req0Valid ? Req0Op    : Req1Op;
  assign sel_addr  = Req0Valid ? Req0Addr  : Req1Addr;
  assign sel_wdata = Req0Valid ? Req0WData : Req1WData;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt_q + CW'(1);
    tcnt_d    = tcnt_q;
    err_d     = err_q;
    accept    = 1'b0;
    accept_id = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!Rst && !busy && (Req0Valid || Req1Valid)) begin
          accept    = 1'b1;
          accept_id = !Req0Valid;
          err_d     = (sel_op == OP_RSVD);
          state_d   = (sel_op == OP_RSVD) ? DONE : ASHIFT;
        end
      end
      ASHIFT: begin
        if (cnt_q == ASHIFT_LAST) begin
          cnt_d   = '0;
          state_d = (op_q == OP_READ)  ? DLOAD :
                    (op_q == OP_WRITE) ? DSHIFT : PULSE;
        end
      end
      DLOAD: begin
        if (cnt_q[0]) begin
          cnt_d   = '0;
          state_d = DSHIFT;
        end
      end
      DSHIFT: begin
        if (cnt_q == DSHIFT_LAST) begin
          cnt_d   = '0;
          state_d = (op_q == OP_READ) ? DONE : PULSE;
        end
      end
      PULSE: begin
        if (cnt_q[0]) begin
          cnt_d   = '0;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (busy) begin
          tcnt_d  = '0;
          state_d = WAIT_LO;
        end else if (cnt_q == RISE_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_LO: begin
        cnt_d = cnt_q;
        if (!busy) begin
          state_d = DONE;
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + TIMEOUT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt_q[0] selects the slot half: 0 = data setup with clock low, 1 = clock high.
  always_comb begin
    Req0Ready  = accept && !accept_id;
    Req1Ready  = accept && accept_id;
    ARShift    = (state == ASHIFT);
    ARCLK      = (state == ASHIFT) && cnt_q[0];
    ARDIn      = (state == ASHIFT) && ash_q[AW-1];
    DRShift    = (state == DSHIFT);
    DRCLK      = ((state == DLOAD) || (state == DSHIFT)) && cnt_q[0];
    DRDIn      = (state == DSHIFT) && (op_q == OP_WRITE) && wsh_q[DW-1];
    UFMProgram = (state == PULSE) && (op_q == OP_WRITE);
    UFMErase   = (state == PULSE) && (op_q == OP_ERASE);
    RspValid   = (state == DONE);
    RspId      = (state == DONE) && id_q;
    RspErr     = (state == DONE) && err_q;
    RspRData   = (state == DONE) ? rsh_q : '0;
  end

  always_ff @(posedge C14M) begin
    if (Rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      tcnt_q <= '0;
      err_q  <= 1'b0;
      op_q   <= OP_READ;
      id_q   <= 1'b0;
      ash_q  <= '0;
      wsh_q  <= '0;
      rsh_q  <= '0;
    end else begin
      state  <= state_d;
      cnt_q  <= cnt_d;
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
      if (accept) begin
        op_q  <= sel_op;
        id_q  <= accept_id;
        ash_q <= sel_addr;
        wsh_q <= sel_wdata;
        rsh_q <= '0;
      end
      if (state == ASHIFT && cnt_q[0])
        ash_q <= {ash_q[AW-2:0], 1'b0};
      if (state == DSHIFT && cnt_q[0])
        wsh_q <= {wsh_q[DW-2:0], 1'b0};
      if (state == DSHIFT && !cnt_q[0] && op_q == OP_READ)
        rsh_q <= {rsh_q[DW-2:0], DRDOut};
    end
  end

endmodule

// File: tb/tb_ufm_sequencer.sv
// tb/tb_ufm_sequencer.sv - randomized self-checking bench with a behavioural UFM model and scoreboard
`timescale 1ns/1ps
module tb_ufm_sequencer;
  import ufm_pkg::*;

  logic        C14M = 1'b0;
  logic        Rst;
  logic        Req0Valid, Req1Valid;
  logic [1:0]  Req0Op, Req1Op;
  logic [8:0]  Req0Addr, Req1Addr;
  logic [15:0] Req0WData, Req1WData;
  logic        Req0Ready, Req1Ready;
  logic        RspValid, RspId, RspErr;
  logic [15:0] RspRData;
  logic        ARCLK, ARDIn, ARShift, DRCLK, DRDIn, DRShift, UFMErase, UFMProgram;
  logic        UFMBusy = 1'b0;
  logic        RTPBusy;
  logic        DRDOut = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 C14M = ~C14M;

  ufm_sequencer #(.TIMEOUT_W(6)) dut (
    .C14M(C14M), .Rst(Rst),
    .Req0Valid(Req0Valid), .Req0Op(Req0Op), .Req0Addr(Req0Addr), .Req0WData(Req0WData), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Op(Req1Op), .Req1Addr(Req1Addr), .Req1WData(Req1WData), .Req1Ready(Req1Ready),
    .RspValid(RspValid), .RspId(RspId), .RspRData(RspRData), .RspErr(RspErr),
    .ARCLK(ARCLK), .ARDIn(ARDIn), .ARShift(ARShift), .DRCLK(DRCLK), .DRDIn(DRDIn), .DRShift(DRShift),
    .UFMErase(UFMErase), .UFMProgram(UFMProgram),
    .UFMBusy(UFMBusy), .RTPBusy(RTPBusy), .DRDOut(DRDOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural UFM: address/data shift registers, array, busy after program/erase.
  logic [15:0] ufm_mem [512];
  logic [15:0] ref_mem [512];
  logic [8:0]  ua = '0;
  logic [15:0] ud = '0;
  int          busy_mode = 0;   // 0 = busy for busy_len cycles, 1 = never busy, 2 = stuck busy
  int          busy_len  = 2;
  int          busy_cnt  = 0;
  logic        stuck = 1'b0;
  logic        prog_q = 1'b0, erase_q = 1'b0, arclk_q = 1'b0, drclk_q = 1'b0;
  int          clk_viol = 0;

  always @(negedge C14M) begin
    if ((ARCLK && arclk_q) || (DRCLK && drclk_q)) clk_viol++;
    arclk_q = ARCLK;
    drclk_q = DRCLK;
    if (ARCLK && ARShift) ua = {ua[7:0], ARDIn};
    if (DRCLK && !DRShift) ud = ufm_mem[ua];
    if (DRCLK && DRShift) ud = {ud[14:0], DRDIn};
    if (busy_cnt > 0) busy_cnt--;
    if (busy_mode != 2) stuck = 1'b0;
    if ((UFMProgram && !prog_q) || (UFMErase && !erase_q)) begin
      if (UFMProgram) ufm_mem[ua] = ud;
      else for (int i = 0; i < 256; i++) ufm_mem[{ua[8], 8'(i)}] = 16'hFFFF;
      if (busy_mode == 0) busy_cnt = busy_len;
      else if (busy_mode == 2) stuck = 1'b1;
    end
    prog_q  = UFMProgram;
    erase_q = UFMErase;
    DRDOut  = ud[15];
    UFMBusy = stuck || (busy_cnt > 0);
  end

  function automatic logic [31:0] all_outs();
    return 32'({Req0Ready, Req1Ready, RspValid, RspId, RspRData, RspErr,
                ARCLK, ARDIn, ARShift, DRCLK, DRDIn, DRShift, UFMErase, UFMProgram});
  endfunction

  task automatic do_txn(input int rid, input logic [1:0] op, input logic [8:0] addr,
                        input logic [15:0] wd, input int mode, input int blen);
    logic [8:0]  a_cap;
    logic [15:0] d_cap, exp_rd, rsp_rd;
    logic        exp_err, rsp_id, rsp_err, got, rdy;
    int          rsp_cyc, pg_first, pg_n, er_first, er_n, dl_n, pin_n, p, exp_cyc;
    a_cap = '0; d_cap = '0; got = 1'b0; rdy = 1'b0;
    rsp_cyc = 0; pg_first = -1; pg_n = 0; er_first = -1; er_n = 0; dl_n = 0; pin_n = 0;
    rsp_id = 1'b0; rsp_err = 1'b0; rsp_rd = '0;
    exp_rd    = (op == OP_READ) ? ref_mem[addr] : 16'h0;
    busy_mode = mode;
    busy_len  = blen;
    if (rid == 0) begin
      Req0Valid = 1'b1; Req0Op = op; Req0Addr = addr; Req0WData = wd;
    end else begin
      Req1Valid = 1'b1; Req1Op = op; Req1Addr = addr; Req1WData = wd;
    end
    for (int t = 0; t < 300 && !rdy; t++) begin
      #1;
      rdy = (rid == 0) ? Req0Ready : Req1Ready;
      if (!rdy) @(negedge C14M);
    end
    check("accept", 32'(rdy), 32'd1);
    @(negedge C14M);
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    for (int c = 1; c <= 400 && rdy && !got; c++) begin
      if (ARCLK) a_cap = {a_cap[7:0], ARDIn};
      if (DRCLK && DRShift) d_cap = {d_cap[14:0], DRDIn};
      if (DRCLK && !DRShift) dl_n++;
      if (UFMProgram) begin pg_n++; if (pg_first < 0) pg_first = c; end
      if (UFMErase) begin er_n++; if (er_first < 0) er_first = c; end
      if (ARCLK || ARDIn || ARShift || DRCLK || DRDIn || DRShift || UFMErase || UFMProgram) pin_n++;
      if (RspValid) begin
        got = 1'b1; rsp_cyc = c; rsp_id = RspId; rsp_err = RspErr; rsp_rd = RspRData;
      end else begin
        @(negedge C14M);
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
    p       = (op == OP_WRITE) ? 51 : 19;
    exp_err = (op == OP_RSVD) || ((op != OP_READ) && (mode != 0));
    if (op == OP_READ)      exp_cyc = 53;
    else if (op == OP_RSVD) exp_cyc = 1;
    else if (mode == 0)     exp_cyc = p + blen + 3;
    else if (mode == 1)     exp_cyc = p + BUSY_RISE_MAX_DEF + 2;
    else                    exp_cyc = p + 66;
    if (got) begin
      check("rsp_cycle", 32'(rsp_cyc), 32'(exp_cyc));
      check("rsp_id", 32'(rsp_id), 32'(rid));
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_rdata", 32'(rsp_rd), 32'(exp_rd));
    end
    if (op != OP_RSVD) check("addr_bits", 32'(a_cap), 32'(addr));
    if (op == OP_READ) check("dload_pulses", 32'(dl_n), 32'd1);
    if (op == OP_WRITE) begin
      check("wdata_bits", 32'(d_cap), 32'(wd));
      check("prog_first", 32'(pg_first), 32'd51);
      check("prog_len", 32'(pg_n), 32'd2);
      check("erase_len_w", 32'(er_n), 32'd0);
    end
    if (op == OP_ERASE) begin
      check("erase_first", 32'(er_first), 32'd19);
      check("erase_len", 32'(er_n), 32'd2);
      check("prog_len_e", 32'(pg_n), 32'd0);
    end
    if (op == OP_RSVD) check("rsvd_pins", 32'(pin_n), 32'd0);
    check("clk_double", 32'(clk_viol), 32'd0);
    if (op == OP_WRITE) ref_mem[addr] = wd;
    if (op == OP_ERASE) for (int i = 0; i < 256; i++) ref_mem[{addr[8], 8'(i)}] = 16'hFFFF;
    busy_mode = 0;
    @(negedge C14M);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen, got, rdy;
    logic [8:0]  a0, a1;
    logic [1:0]  rop;
    int          r, m;

    for (int i = 0; i < 512; i++) begin
      ufm_mem[i] = 16'($urandom);
      ref_mem[i] = ufm_mem[i];
    end
    Rst = 1'b1; RTPBusy = 1'b0;
    Req0Valid = 1'b0; Req0Op = '0; Req0Addr = '0; Req0WData = '0;
    Req1Valid = 1'b0; Req1Op = '0; Req1Addr = '0; Req1WData = '0;
    repeat (3) @(negedge C14M);
    check("reset_outs", all_outs(), 32'd0);
    Rst = 1'b0;
    @(negedge C14M);

    ufm_mem[9'h1A5] = 16'hA55A;
    ref_mem[9'h1A5] = 16'hA55A;
    do_txn(1, OP_READ,  9'h1A5, 16'h0000, 0, 2);
    do_txn(0, OP_WRITE, 9'h003, 16'h7E01, 0, 40);
    do_txn(1, OP_READ,  9'h003, 16'h0000, 0, 2);
    do_txn(1, OP_ERASE, 9'h100, 16'h0000, 1, 2);
    do_txn(0, OP_READ,  9'h1A5, 16'h0000, 0, 2);
    do_txn(0, OP_WRITE, 9'h0F0, 16'h1234, 2, 2);
    do_txn(1, OP_RSVD,  9'h055, 16'hBEEF, 0, 2);

    // Busy from the RTP side while idle must hold off acceptance.
    RTPBusy = 1'b1;
    repeat (3) @(negedge C14M);
    Req1Valid = 1'b1; Req1Op = OP_READ; Req1Addr = 9'h0F0;
    seen = 1'b0;
    repeat (30) begin
      #1;
      if (Req1Ready) seen = 1'b1;
      @(negedge C14M);
    end
    check("rtp_hold", 32'(seen), 32'd0);
    RTPBusy = 1'b0;
    do_txn(1, OP_READ, 9'h0F0, 16'h0000, 0, 2);

    // Simultaneous requests: Req0 first, Req1 accepted right after Req0's response.
    a0 = 9'h011; a1 = 9'h122;
    Req0Valid = 1'b1; Req0Op = OP_READ; Req0Addr = a0;
    Req1Valid = 1'b1; Req1Op = OP_READ; Req1Addr = a1;
    #1;
    check("arb_ready0", 32'(Req0Ready), 32'd1);
    check("arb_ready1", 32'(Req1Ready), 32'd0);
    @(negedge C14M);
    Req0Valid = 1'b0;
    got = 1'b0; seen = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (Req1Ready) seen = 1'b1;
      if (RspValid) begin
        got = 1'b1;
        check("arb_id0", 32'(RspId), 32'd0);
        check("arb_rdata0", 32'(RspRData), 32'(ref_mem[a0]));
      end else @(negedge C14M);
    end
    check("arb_rsp0", 32'(got), 32'd1);
    check("arb_r1_early", 32'(seen), 32'd0);
    @(negedge C14M);
    check("arb_r1_next", 32'(Req1Ready), 32'd1);
    @(negedge C14M);
    Req1Valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (RspValid) begin
        got = 1'b1;
        check("arb_id1", 32'(RspId), 32'd1);
        check("arb_rdata1", 32'(RspRData), 32'(ref_mem[a1]));
      end else @(negedge C14M);
    end
    check("arb_rsp1", 32'(got), 32'd1);
    @(negedge C14M);

    // Reset in the middle of a read data shift abandons it silently.
    Req1Valid = 1'b1; Req1Op = OP_READ; Req1Addr = 9'h1A5;
    rdy = 1'b0;
    for (int t = 0; t < 20 && !rdy; t++) begin
      #1;
      rdy = Req1Ready;
      if (!rdy) @(negedge C14M);
    end
    check("rst_accept", 32'(rdy), 32'd1);
    @(negedge C14M);
    Req1Valid = 1'b0;
    repeat (29) @(negedge C14M);
    check("rst_in_dshift", 32'(DRShift), 32'd1);
    Rst = 1'b1;
    @(negedge C14M);
    check("rst_outs", all_outs(), 32'd0);
    Rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      if (RspValid) seen = 1'b1;
      @(negedge C14M);
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    do_txn(1, OP_READ, 9'h1A5, 16'h0000, 0, 2);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      rop = (r < 4) ? OP_READ : (r < 7) ? OP_WRITE : (r < 9) ? OP_ERASE : OP_RSVD;
      m = $urandom_range(0, 7);
      m = (m < 6) ? 0 : (m == 6) ? 1 : 2;
      do_txn($urandom_range(0, 1), rop, 9'($urandom), 16'($urandom), m, $urandom_range(2, 60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
